// File: rtl/gather.sv
// gather: deserializes a scalar sample stream into DEPTH-lane vectors through a two-slot ping-pong buffer.
// Latency: the vector is presented in the cycle right after its completing sample is accepted.
// Backpressure: input_ready drops only when both slots hold complete vectors; it comes purely from registers.
module gather #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          input_valid,
  input  logic [WIDTH-1:0]              input_data,
  input  logic                          input_last,
  output logic                          input_ready,
  output logic                          output_valid,
  output logic [DEPTH-1:0][WIDTH-1:0]   output_data,
  output logic                          output_short,
  input  logic                          output_ready
);

  localparam int LW = $clog2(DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(DEPTH - 1);

  // Two vector slots. A slot is only exposed once it holds a complete vector.
  logic [DEPTH-1:0][WIDTH-1:0] slot_data [2];
  logic [1:0]                  slot_short;

  logic          wr;
  logic          rd;
  logic [1:0]    count;
  logic [LW-1:0] lane;

  logic          accept;
  logic          complete;
  logic          take;
  logic [1:0]    count_next;

  // Handshakes that coincide with reset are dropped so no state can leak through it.
  assign accept   = input_valid && input_ready && !reset;
  assign complete = accept && ((lane == LAST_LANE) || input_last);
  assign take     = output_valid && output_ready && !reset;

  // The presented vector is always the slot at the read pointer.
  assign output_data  = slot_data[rd];
  assign output_short = slot_short[rd];

  // Occupancy update: a completion and a hand-off in the same cycle cancel out.
  always_comb begin
    count_next = count;
    case ({complete, take})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Pointers, lane index, occupancy and the registered handshake flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr           <= 1'b0;
      rd           <= 1'b0;
      count        <= 2'd0;
      lane         <= '0;
      input_ready  <= 1'b1;
      output_valid <= 1'b0;
    end else begin
      count        <= count_next;
      input_ready  <= (count_next != 2'd2);
      output_valid <= (count_next != 2'd0);
      if (complete) begin
        wr   <= ~wr;
        lane <= '0;
      end else if (accept) begin
        lane <= lane + 1'b1;
      end
      if (take) begin
        rd <= ~rd;
      end
    end
  end

  // Slot storage: write the incoming lane; on completion zero every lane above it and record the short flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        slot_data[s] <= '0;
      end
      slot_short <= 2'b00;
    end else if (accept) begin
      for (int l = 0; l < DEPTH; l++) begin
        if (LW'(l) == lane) begin
          slot_data[wr][LW'(l)] <= input_data;
        end else if (complete && (LW'(l) > lane)) begin
          slot_data[wr][LW'(l)] <= '0;
        end
      end
      if (complete) begin
        slot_short[wr] <= input_last && (lane != LAST_LANE);
      end
    end
  end

endmodule

// File: tb/tb_gather.sv
// Bench for gather: DEPTH=2 instance driven from a vector table and hand sequences,
// plus a DEPTH=4 instance under random output backpressure. Expected vectors queue up
// when their completing sample is driven and are popped when the DUT hands them off.
module tb_gather;

  typedef struct {
    logic [31:0] vec;
    logic        sh;
  } exp_t;

  typedef struct {
    logic [7:0]  d;
    logic        last;
    logic        done;
    logic [15:0] vec;
    logic        sh;
  } row_t;

  logic clock;
  logic reset;

  // DEPTH=2 instance
  logic             input_valid;
  logic [7:0]       input_data;
  logic             input_last;
  logic             input_ready;
  logic             output_valid;
  logic [1:0][7:0]  output_data;
  logic             output_short;
  logic             output_ready;

  // DEPTH=4 instance
  logic             b_input_valid;
  logic [7:0]       b_input_data;
  logic             b_input_last;
  logic             b_input_ready;
  logic             b_output_valid;
  logic [3:0][7:0]  b_output_data;
  logic             b_output_short;
  logic             b_output_ready;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  row_t tbl[$];

  logic        b_stalled = 1'b0;
  logic [31:0] b_hold_data;
  logic        b_hold_short;

  gather #(.WIDTH(8), .DEPTH(2)) dut_a (
    .clock(clock), .reset(reset),
    .input_valid(input_valid), .input_data(input_data), .input_last(input_last),
    .input_ready(input_ready),
    .output_valid(output_valid), .output_data(output_data), .output_short(output_short),
    .output_ready(output_ready)
  );

  gather #(.WIDTH(8), .DEPTH(4)) dut_b (
    .clock(clock), .reset(reset),
    .input_valid(b_input_valid), .input_data(b_input_data), .input_last(b_input_last),
    .input_ready(b_input_ready),
    .output_valid(b_output_valid), .output_data(b_output_data), .output_short(b_output_short),
    .output_ready(b_output_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Offer one sample to the DEPTH=2 DUT and return after the edge that accepts it.
  task automatic put_a(input logic [7:0] d, input logic last, output int stalls);
    int w;
    w = 0;
    input_valid = 1'b1;
    input_data  = d;
    input_last  = last;
    while (!input_ready && w < 100) begin
      @(posedge clock); #1;
      w++;
    end
    if (w >= 100) begin
      n_checks++;
      $display("FAIL put_a_timeout: input_ready stayed 0 for %0d cycles, required 1", w);
    end
    @(posedge clock); #1;
    stalls = w;
  endtask

  task automatic put_b(input logic [7:0] d, input logic last);
    int w;
    w = 0;
    b_input_valid = 1'b1;
    b_input_data  = d;
    b_input_last  = last;
    while (!b_input_ready && w < 100) begin
      @(posedge clock); #1;
      w++;
    end
    if (w >= 100) begin
      n_checks++;
      $display("FAIL put_b_timeout: b_input_ready stayed 0 for %0d cycles, required 1", w);
    end
    @(posedge clock); #1;
    b_input_valid = 1'b0;
  endtask

  task automatic push_a(input logic [15:0] v, input logic s);
    exp_t e;
    e.vec = 32'(v);
    e.sh  = s;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] v, input logic s);
    exp_t e;
    e.vec = v;
    e.sh  = s;
    qb.push_back(e);
  endtask

  task automatic drain_a(input string name);
    int w;
    w = 0;
    while (qa.size() != 0 && w < 200) begin
      @(posedge clock); #1;
      w++;
    end
    check(name, 64'(qa.size()), 64'd0);
  endtask

  task automatic drain_b(input string name);
    int w;
    w = 0;
    while (qb.size() != 0 && w < 400) begin
      @(posedge clock); #1;
      w++;
    end
    check(name, 64'(qb.size()), 64'd0);
  endtask

  // Scoreboard for the DEPTH=2 DUT: a handshake seen here completes on the next rising edge.
  always @(negedge clock) begin
    if (!reset && output_valid && output_ready) begin
      if (qa.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected: got vector %0h, expected none", output_data);
      end else begin
        ea = qa.pop_front();
        check("a_vec", 64'(output_data), 64'(ea.vec));
        check("a_short", 64'(output_short), 64'(ea.sh));
      end
    end
  end

  // Scoreboard for the DEPTH=4 DUT, plus hold-stable checks across stalled cycles.
  always @(negedge clock) begin
    if (!reset && b_stalled && b_output_valid) begin
      check("b_hold_data", 64'(b_output_data), 64'(b_hold_data));
      check("b_hold_short", 64'(b_output_short), 64'(b_hold_short));
    end
    if (!reset && b_output_valid && b_output_ready) begin
      if (qb.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected: got vector %0h, expected none", b_output_data);
      end else begin
        eb = qb.pop_front();
        check("b_vec", 64'(b_output_data), 64'(eb.vec));
        check("b_short", 64'(b_output_short), 64'(eb.sh));
      end
    end
    b_stalled    = !reset && b_output_valid && !b_output_ready;
    b_hold_data  = b_output_data;
    b_hold_short = b_output_short;
  end

  initial begin
    row_t r;
    logic [7:0] prev_d;
    int st;
    int stall_sum;

    // Vector table: 20-sample back-to-back stream, a last on the final lane,
    // a short vector landing on a slot with stale data, then a normal vector.
    prev_d = 8'h00;
    for (int i = 0; i < 20; i++) begin
      r.d    = 8'(8'h30 + i);
      r.last = 1'b0;
      r.done = (i % 2) == 1;
      r.vec  = {r.d, prev_d};
      r.sh   = 1'b0;
      tbl.push_back(r);
      prev_d = r.d;
    end
    r = '{d: 8'h9A, last: 1'b0, done: 1'b0, vec: 16'h0000, sh: 1'b0}; tbl.push_back(r);
    r = '{d: 8'h9B, last: 1'b1, done: 1'b1, vec: 16'h9B9A, sh: 1'b0}; tbl.push_back(r);
    r = '{d: 8'h7F, last: 1'b1, done: 1'b1, vec: 16'h007F, sh: 1'b1}; tbl.push_back(r);
    r = '{d: 8'h01, last: 1'b0, done: 1'b0, vec: 16'h0000, sh: 1'b0}; tbl.push_back(r);
    r = '{d: 8'h02, last: 1'b0, done: 1'b1, vec: 16'h0201, sh: 1'b0}; tbl.push_back(r);

    reset          = 1'b1;
    input_valid    = 1'b0;
    input_data     = 8'h00;
    input_last     = 1'b0;
    output_ready   = 1'b0;
    b_input_valid  = 1'b0;
    b_input_data   = 8'h00;
    b_input_last   = 1'b0;
    b_output_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_out_valid", 64'(output_valid), 64'd0);
    check("rst_out_data", 64'(output_data), 64'd0);
    check("rst_out_short", 64'(output_short), 64'd0);
    check("rst_in_ready", 64'(input_ready), 64'd1);
    check("rst_b_out_data", 64'(b_output_data), 64'd0);
    check("rst_b_in_ready", 64'(b_input_ready), 64'd1);

    // Basic vector and its one-cycle presentation with a ready consumer.
    output_ready = 1'b1;
    put_a(8'h11, 1'b0, st);
    put_a(8'h22, 1'b0, st);
    push_a(16'h2211, 1'b0);
    input_valid = 1'b0;
    check("latency_valid", 64'(output_valid), 64'd1);
    check("latency_data", 64'(output_data), 64'h2211);
    @(posedge clock); #1;
    check("valid_drops", 64'(output_valid), 64'd0);

    // Table-driven stream with the consumer always ready.
    stall_sum = 0;
    foreach (tbl[i]) begin
      put_a(tbl[i].d, tbl[i].last, st);
      stall_sum += st;
      if (tbl[i].done) push_a(tbl[i].vec, tbl[i].sh);
    end
    input_valid = 1'b0;
    check("stream_no_stall", 64'(stall_sum), 64'd0);
    drain_a("table_drain");
    check("table_idle_valid", 64'(output_valid), 64'd0);

    // Full buffer: two vectors waiting, input must stall until one is taken.
    output_ready = 1'b0;
    put_a(8'hA1, 1'b0, st);
    put_a(8'hA2, 1'b0, st); push_a(16'hA2A1, 1'b0);
    put_a(8'hA3, 1'b0, st);
    put_a(8'hA4, 1'b0, st); push_a(16'hA4A3, 1'b0);
    input_valid = 1'b0;
    check("full_ready_low", 64'(input_ready), 64'd0);
    check("full_front_data", 64'(output_data), 64'hA2A1);
    @(posedge clock); #1;
    check("full_still_low", 64'(input_ready), 64'd0);
    output_ready = 1'b1;
    @(posedge clock); #1;
    output_ready = 1'b0;
    check("full_ready_rises", 64'(input_ready), 64'd1);
    put_a(8'hA5, 1'b0, st);
    put_a(8'hA6, 1'b0, st); push_a(16'hA6A5, 1'b0);
    input_valid = 1'b0;
    check("refull_ready_low", 64'(input_ready), 64'd0);
    output_ready = 1'b1;
    drain_a("full_drain");

    // Partial vector discarded by reset.
    put_a(8'h55, 1'b0, st);
    input_valid = 1'b0;
    check("partial_hidden", 64'(output_valid), 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst2_out_valid", 64'(output_valid), 64'd0);
    check("rst2_out_data", 64'(output_data), 64'd0);
    check("rst2_in_ready", 64'(input_ready), 64'd1);
    put_a(8'h01, 1'b0, st);
    put_a(8'h02, 1'b0, st); push_a(16'h0201, 1'b0);
    input_valid = 1'b0;
    drain_a("reset_drain");

    // DEPTH=4 under random backpressure; short vectors land on slots holding stale lanes.
    fork
      begin
        put_b(8'h01, 1'b0); put_b(8'h02, 1'b0); put_b(8'h03, 1'b0); put_b(8'h04, 1'b0);
        push_b(32'h04030201, 1'b0);
        put_b(8'h08, 1'b0); put_b(8'h09, 1'b0); put_b(8'h0A, 1'b0); put_b(8'h0B, 1'b1);
        push_b(32'h0B0A0908, 1'b0);
        put_b(8'h10, 1'b0); put_b(8'h20, 1'b1);
        push_b(32'h00002010, 1'b1);
        put_b(8'h05, 1'b0); put_b(8'h06, 1'b0); put_b(8'h07, 1'b1);
        push_b(32'h00070605, 1'b1);
      end
      begin
        repeat (80) begin
          @(posedge clock); #1;
          b_output_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    b_output_ready = 1'b1;
    drain_b("b_drain");

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gather.md
# gather

Upstream stage for `node`: deserializes a scalar stream of signed WIDTH-bit samples into DEPTH-lane vectors matching `node`'s `input_data` layout. A two-slot ping-pong buffer lets the next vector assemble while the previous one waits on `node`. This sustains one sample per cycle whenever the consumer keeps up. An `input_last` marker terminates short vectors, which are zero-padded.

## Interface
- `WIDTH`, 8, sample width in bits; must equal the `node` WIDTH.
- `DEPTH`, 2, lanes per output vector, ≥ 2; must equal the `node` DEPTH.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high; clock clock.
- `input_valid`  in  1  sample present.
- `input_data`  in  WIDTH  sample.
- `input_last`  in  1  sample is the final one of its vector.
- `input_ready`  out  1  sample accepted when high with `input_valid`.
- `output_valid`  out  1  vector present.
- `output_data`  out  DEPTH×WIDTH  packed `[DEPTH-1:0][WIDTH-1:0]`; lane 0 is the first sample received.
- `output_short`  out  1  vector was terminated early by `input_last` and padded.
- `output_ready`  in  1  vector consumed when high with `output_valid`.

## Operation
- Storage:
  - Two vector slots, each DEPTH lanes plus a short flag.
  - Write pointer `wr` (1 bit), read pointer `rd` (1 bit), occupancy `count` (0..2).
  - Lane index `lane` (0..DEPTH-1).
- Input handshake: `input_ready = (count != 2)`. It is driven from registers only, with no combinational path from `output_ready`.
- On each accepted sample:
  - Write `input_data` to `slot[wr].lane[lane]`.
  - If `lane == DEPTH-1` or `input_last`, the vector completes.
  - Otherwise `lane` increments.
- On vector completion:
  - Lanes above `lane` in `slot[wr]` are cleared to 0 in the same cycle.
  - `short = input_last && lane != DEPTH-1`.
  - `lane` returns to 0, `wr` toggles and `count` increments.
- `input_last` on lane DEPTH-1 is a normal completion with `short = 0`.
- Output side:
  - `output_valid = (count != 0)`, registered.
  - `output_data` and `output_short` reflect `slot[rd]`.
  - On handshake, `rd` toggles and `count` decrements.
- Simultaneous completion and output handshake: `count` is unchanged and both pointers toggle.
- `output_data` and `output_short` hold stable while `output_valid && !output_ready`.
- A partially filled vector is never presented. Samples already written stay in `slot[wr]` until completion.
- Arithmetic: none. Samples pass through bit-exact and are treated as opaque two's-complement values.
- Reset:
  - `count`, `wr`, `rd` and `lane` go to 0.
  - All slot contents and short flags clear to 0.
  - Any partial vector is discarded.
  - Handshakes coincident with `reset` are ignored.

## Timing
- Output values after reset:
  - `output_valid = 0`, `output_data = 0`, `output_short = 0`.
  - `input_ready = 1` from the first cycle after reset deasserts.
- Latency: when the completing sample is accepted at edge t, `output_valid` is high and the vector is presented after edge t, with no extra cycle.
- Throughput: one sample per cycle while the consumer accepts within DEPTH cycles of presentation.
- Full, with `count == 2`:
  - `input_ready` is low.
  - An output handshake at edge t raises `input_ready` after edge t.
  - No sample is lost or overwritten.
- Empty, with `count == 0`: `output_valid` is low; `output_ready` is ignored.
- Pointer wrap: `wr`/`rd` toggle modulo 2. `lane` wraps DEPTH-1 → 0 on completion only.

## Test plan
(WIDTH=8, DEPTH=2 unless stated.)
- Stream 0x11, 0x22 with `output_ready=1` → `output_data` lane0=0x11, lane1=0x22, `output_short=0`. `output_valid` is high the cycle after 0x22 is accepted and low the following cycle.
- Send 0x7F with `input_last=1` → lane0=0x7F, lane1=0x00, `output_short=1`. The next vector 0x01, 0x02 shows `output_short=0`.
- Hold `output_ready=0` and stream 0xA1..0xA6:
  - After 4 samples `input_ready=0`.
  - Pulse `output_ready` → (0xA1,0xA2) is consumed and `input_ready` rises next cycle.
  - All three vectors arrive in order, intact.
- Continuous back-to-back stream of 20 samples with `output_ready=1` → `input_ready` never drops and 10 vectors are emitted in order. Completion coinciding with the output handshake leaves `count` correct.
- Accept 0x55 as a partial vector, assert `reset` for one cycle, then send 0x01, 0x02 → a single vector (0x01, 0x02); 0x55 never appears. `output_valid=0` and `output_data=0` immediately after reset.
- DEPTH=4: send 0x10, 0x20 (last) → (0x10, 0x20, 0, 0) with `output_short=1`. Randomized `output_ready` backpressure causes no data change while the vector is stalled.
